// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream pattern source: FSM state encoding
// and a byte-strobe helper.
package axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // All-ones strobe for a data bus of dw bits; callers size-cast to their strobe width.
    function automatic logic [127:0] STRB_ALL(input int dw);
        return (128'd1 << (dw / 8)) - 128'd1;
    endfunction

endpackage

// File: rtl/axis_pattern_source.sv
// AXI-Stream master that sends one frame of incrementing data per start command,
// honouring tready backpressure and counting completed frames.
module axis_pattern_source
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    m01_axis_aclk,
    input  logic                    m01_axis_aresetn,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    frame_len,
    input  logic [DATA_WIDTH-1:0]   seed,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    frame_count,
    input  logic                    m01_axis_tready,
    output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
    output logic                    m01_axis_tvalid,
    output logic                    m01_axis_tlast
);

    localparam int STRB_W = DATA_WIDTH / 8;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_beat_cnt;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [CNT_WIDTH-1:0]   r_frame_count;

    logic w_launch;
    logic w_accept;
    logic w_last_beat;

    // Zero-length commands are dropped here so the FSM never enters SEND with nothing to send.
    assign w_launch    = (r_state == ST_IDLE) && start && (frame_len != '0);
    assign w_accept    = (r_state == ST_SEND) && m01_axis_tready;
    assign w_last_beat = (r_beat_cnt == r_len - LEN_WIDTH'(1));

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge m01_axis_aclk or negedge m01_axis_aresetn) begin
        if (!m01_axis_aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: defaulting every combinational output first prevents latch inference.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_launch)                 w_next_state = ST_SEND;
            ST_SEND: if (w_accept && w_last_beat)  w_next_state = ST_DONE;
            ST_DONE:                               w_next_state = ST_IDLE;
            default:                               w_next_state = ST_IDLE;
        endcase
    end

    // Data register and beat counter only move on launch or on an accepted
    // non-final beat, which keeps tdata/tlast frozen through stalls.
    always_ff @(posedge m01_axis_aclk or negedge m01_axis_aresetn) begin
        if (!m01_axis_aresetn) begin
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_data     <= '0;
        end else if (w_launch) begin
            r_len      <= frame_len;
            r_beat_cnt <= '0;
            r_data     <= seed;
        end else if (w_accept && !w_last_beat) begin
            r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
            r_data     <= r_data + DATA_WIDTH'(1);
        end
    end

    always_ff @(posedge m01_axis_aclk or negedge m01_axis_aresetn) begin
        if (!m01_axis_aresetn) begin
            r_frame_count <= '0;
        end else if (r_state == ST_DONE) begin
            r_frame_count <= r_frame_count + CNT_WIDTH'(1);
        end
    end

    // Outputs decode flops only, so tready never reaches an output combinationally.
    always_comb begin
        m01_axis_tvalid = 1'b0;
        m01_axis_tlast  = 1'b0;
        m01_axis_tstrb  = '0;
        done            = 1'b0;
        busy            = 1'b0;
        case (r_state)
            ST_SEND: begin
                m01_axis_tvalid = 1'b1;
                m01_axis_tlast  = w_last_beat;
                m01_axis_tstrb  = STRB_W'(STRB_ALL(DATA_WIDTH));
                busy            = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign m01_axis_tdata = r_data;
    assign frame_count    = r_frame_count;

endmodule

// File: tb/tb_axis_pattern_source.sv
// Directed, table-driven bench for axis_pattern_source: per-cycle vectors of
// inputs and hand-computed expected outputs, plus reset corner sequences.
module tb_axis_pattern_source;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] frame_len = '0;
    logic [31:0] seed = '0;
    logic        tready = 1'b0;
    logic        busy, done, tvalid, tlast;
    logic [15:0] frame_count;
    logic [31:0] tdata;
    logic [3:0]  tstrb;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rdy;
        logic        st;
        logic [11:0] flen;
        logic [31:0] sd;
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        dn;
        logic        bsy;
        logic [15:0] fc;
    } vec_t;

    vec_t q[$];

    axis_pattern_source dut (
        .m01_axis_aclk    (clk),
        .m01_axis_aresetn (rst_n),
        .start            (start),
        .frame_len        (frame_len),
        .seed             (seed),
        .busy             (busy),
        .done             (done),
        .frame_count      (frame_count),
        .m01_axis_tready  (tready),
        .m01_axis_tdata   (tdata),
        .m01_axis_tstrb   (tstrb),
        .m01_axis_tvalid  (tvalid),
        .m01_axis_tlast   (tlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic st, input logic [11:0] flen,
                       input logic [31:0] sd, input logic valid, input logic [31:0] data,
                       input logic last, input logic dn, input logic bsy, input logic [15:0] fc);
        vec_t v;
        v.rdy = rdy; v.st = st; v.flen = flen; v.sd = sd;
        v.valid = valid; v.data = data; v.last = last; v.dn = dn; v.bsy = bsy; v.fc = fc;
        q.push_back(v);
    endtask

    // Each entry: inputs for the coming edge, outputs expected in the current cycle.
    task automatic run_vec(input string tag);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            tready    = q[i].rdy;
            start     = q[i].st;
            frame_len = q[i].flen;
            seed      = q[i].sd;
            check($sformatf("%s[%0d].tvalid", tag, i), 64'(tvalid), 64'(q[i].valid));
            check($sformatf("%s[%0d].tdata", tag, i), 64'(tdata), 64'(q[i].data));
            check($sformatf("%s[%0d].tlast", tag, i), 64'(tlast), 64'(q[i].last));
            check($sformatf("%s[%0d].tstrb", tag, i), 64'(tstrb), q[i].valid ? 64'hF : 64'h0);
            check($sformatf("%s[%0d].done", tag, i), 64'(done), 64'(q[i].dn));
            check($sformatf("%s[%0d].busy", tag, i), 64'(busy), 64'(q[i].bsy));
            check($sformatf("%s[%0d].frame_count", tag, i), 64'(frame_count), 64'(q[i].fc));
        end
        q.delete();
    endtask

    task automatic launch(input logic [11:0] len, input logic [31:0] sd);
        @(negedge clk);
        start     = 1'b1;
        frame_len = len;
        seed      = sd;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".tvalid"}, 64'(tvalid), 64'h0);
        check({tag, ".tlast"}, 64'(tlast), 64'h0);
        check({tag, ".tstrb"}, 64'(tstrb), 64'h0);
        check({tag, ".tdata"}, 64'(tdata), 64'h0);
        check({tag, ".done"}, 64'(done), 64'h0);
        check({tag, ".busy"}, 64'(busy), 64'h0);
        check({tag, ".frame_count"}, 64'(frame_count), 64'h0);
    endtask

    initial begin
        #2 check_reset_state("reset");
        #2 rst_n = 1'b1;

        // len=3, continuous ready
        launch(12'd3, 32'h55);
        //  rdy st flen seed  valid data  last done busy fc
        add(1, 0, 0, 0,       1, 32'h55, 0, 0, 1, 0);
        add(1, 0, 0, 0,       1, 32'h56, 0, 0, 1, 0);
        add(1, 0, 0, 0,       1, 32'h57, 1, 0, 1, 0);
        add(1, 0, 0, 0,       0, 32'h57, 0, 1, 1, 0);
        add(1, 0, 0, 0,       0, 32'h57, 0, 0, 0, 1);
        run_vec("len3");

        // len=4 with ready pattern 1,0,0,1,0,1,1
        launch(12'd4, 32'h22);
        add(1, 0, 0, 0,       1, 32'h22, 0, 0, 1, 1);
        add(0, 0, 0, 0,       1, 32'h23, 0, 0, 1, 1);
        add(0, 0, 0, 0,       1, 32'h23, 0, 0, 1, 1);
        add(1, 0, 0, 0,       1, 32'h23, 0, 0, 1, 1);
        add(0, 0, 0, 0,       1, 32'h24, 0, 0, 1, 1);
        add(1, 0, 0, 0,       1, 32'h24, 0, 0, 1, 1);
        add(1, 0, 0, 0,       1, 32'h25, 1, 0, 1, 1);
        add(1, 0, 0, 0,       0, 32'h25, 0, 1, 1, 1);
        add(1, 0, 0, 0,       0, 32'h25, 0, 0, 0, 2);
        run_vec("stall");

        // Data wrap; start during SEND and DONE must be ignored
        launch(12'd3, 32'hFFFF_FFFE);
        add(1, 1, 5, 32'h1234, 1, 32'hFFFF_FFFE, 0, 0, 1, 2);
        add(1, 1, 5, 32'h1234, 1, 32'hFFFF_FFFF, 0, 0, 1, 2);
        add(1, 0, 0, 0,        1, 32'h0000_0000, 1, 0, 1, 2);
        add(1, 1, 5, 32'h1234, 0, 32'h0000_0000, 0, 1, 1, 2);
        add(1, 0, 0, 0,        0, 32'h0000_0000, 0, 0, 0, 3);
        run_vec("wrap");

        // Zero-length start is dropped
        launch(12'd0, 32'h99);
        add(1, 0, 0, 0,       0, 32'h0, 0, 0, 0, 3);
        add(1, 0, 0, 0,       0, 32'h0, 0, 0, 0, 3);
        run_vec("len0");

        // len=1 with start held high: next frame starts at M+2
        launch(12'd1, 32'h24);
        add(1, 1, 1, 32'h30,  1, 32'h24, 1, 0, 1, 3);
        add(1, 1, 1, 32'h30,  0, 32'h24, 0, 1, 1, 3);
        add(1, 1, 1, 32'h30,  0, 32'h24, 0, 0, 0, 4);
        add(1, 0, 0, 0,       1, 32'h30, 1, 0, 1, 4);
        add(1, 0, 0, 0,       0, 32'h30, 0, 1, 1, 4);
        add(1, 0, 0, 0,       0, 32'h30, 0, 0, 0, 5);
        run_vec("b2b");

        // Reset after the 2nd of 5 beats
        launch(12'd5, 32'h100);
        add(1, 0, 0, 0,       1, 32'h100, 0, 0, 1, 5);
        add(1, 0, 0, 0,       1, 32'h101, 0, 0, 1, 5);
        run_vec("pre_rst");
        @(negedge clk);
        check("mid.tdata", 64'(tdata), 64'h102);
        #2 rst_n = 1'b0;
        #1 check_reset_state("mid_reset");
        @(posedge clk);
        #1 check_reset_state("held_reset");
        #1 rst_n = 1'b1;

        launch(12'd2, 32'hABC);
        add(1, 0, 0, 0,       1, 32'hABC, 0, 0, 1, 0);
        add(1, 0, 0, 0,       1, 32'hABD, 1, 0, 1, 0);
        add(1, 0, 0, 0,       0, 32'hABD, 0, 1, 1, 0);
        add(1, 0, 0, 0,       0, 32'hABD, 0, 0, 0, 1);
        run_vec("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_pattern_source.md
# axis_pattern_source

AXI-Stream master that transmits frames of a programmable length with an incrementing data pattern. It is the transmit end for the `memory_wrapper` slave port (`s01_axis_*`) and replaces hand-driven stimulus on that interface. A single-cycle command launches a frame. The block honours `tready` backpressure, marks the final beat with `tlast`, pulses `done` after the frame completes, and keeps a count of completed frames.

## Interface
- `DATA_WIDTH`, 32, width of `tdata`; must be a multiple of 8.
- `LEN_WIDTH`, 12, width of `frame_len`; maximum frame is 2^LEN_WIDTH − 1 beats.
- `CNT_WIDTH`, 16, width of `frame_count`.

- `m01_axis_aclk` in 1: single clock; all logic is on its rising edge.
- `m01_axis_aresetn` in 1: reset, asynchronous, active-low.
- `start` in 1: launches a frame; sampled only in IDLE.
- `frame_len` in LEN_WIDTH: number of beats; sampled with `start`.
- `seed` in DATA_WIDTH: data value of the first beat; sampled with `start`.
- `busy` out 1: high in SEND and DONE.
- `done` out 1: one-cycle pulse after the last beat is accepted.
- `frame_count` out CNT_WIDTH: number of completed frames; wraps.
- `m01_axis_tready` in 1: sink ready.
- `m01_axis_tdata` out DATA_WIDTH: beat data.
- `m01_axis_tstrb` out DATA_WIDTH/8: all ones whenever `tvalid` is high, zero otherwise.
- `m01_axis_tvalid` out 1: beat valid.
- `m01_axis_tlast` out 1: final beat of the frame.

## Operation
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - `start`=1 and `frame_len`≠0: latch `len`, load the data register with `seed`, clear `beat_cnt`, go to SEND.
  - `start`=1 and `frame_len`=0: ignored; stay in IDLE, no `done`.
- SEND:
  - `tvalid`=1.
  - `tdata` = data register.
  - `tlast` = (`beat_cnt` == `len`−1).
  - A beat is accepted when `tvalid` & `tready`.
  - On accept (not last): data register +1, modulo 2^DATA_WIDTH (wraps from all-ones to 0); `beat_cnt` +1.
  - On accept of the last beat: go to DONE.
- DONE:
  - `tvalid`=0 and `done`=1 for exactly one cycle.
  - `frame_count` increments, wrapping at 2^CNT_WIDTH.
  - Go to IDLE.
- `start` is ignored in SEND and DONE; no queueing.
- AXIS stability: while `tvalid`=1 and `tready`=0, `tdata`, `tstrb` and `tlast` are held unchanged.
- `tvalid` never drops before the current beat is accepted.

## Timing
- Reset values: state IDLE; `tvalid`, `tlast`, `done`, `busy` = 0; `tdata` = 0; `tstrb` = 0; `frame_count` = 0.
- All outputs are registered. No combinational path from `tready` to any output.
- `start` sampled at edge N → `tvalid`=1 and `busy`=1 after edge N.
- Throughput is 1 beat/cycle while `tready` is held high. A frame of L beats with continuous `tready` spans L cycles in SEND plus 1 cycle in DONE.
- Last beat accepted at edge M → `done`=1 during cycle M..M+1, and `frame_count` is updated at edge M+1.
- Minimum spacing between frames: `start` is next accepted at edge M+2, when the FSM is back in IDLE.
- `len`=1: the first beat carries `tlast`=1.
- `tready` toggling every cycle: each beat is presented until accepted; no beat is duplicated or skipped.
- Reset asserted mid-frame: outputs go to their reset values immediately (asynchronously). No `tlast`, no `done`, `frame_count` cleared. The frame is abandoned; the sink sees a truncated frame.
- Reset deassertion: the first `start` is honoured at the first rising edge after `m01_axis_aresetn` goes high.

## Structure
- Shared package `axis_pkg`:
  - state encoding constants `ST_IDLE`, `ST_SEND`, `ST_DONE` (2-bit);
  - helper `STRB_ALL(DATA_WIDTH)` = all-ones strobe.
- No sub-module. Single module containing the FSM, beat counter, data register and frame counter; roughly 150 lines.
- Top-level bench pairs this block with `memory_wrapper` (`m01_*` of this block → `s01_*` of the wrapper).

## Test plan
- Reset: `aresetn`=0 for 4 ns → `tvalid`=0, `tstrb`=0, `frame_count`=0, `busy`=0.
- `start` with `len`=3, `seed`=32'h0055, `tready` held 1 → beats 0x55, 0x56, 0x57 on consecutive cycles; `tlast` only on 0x57; `done` pulses one cycle later; `frame_count`=1.
- `len`=4, `seed`=32'h0022, `tready` pattern 1,0,0,1,0,1,1 → exactly 4 accepts (0x22–0x25); `tdata`/`tlast` stable during stalls; `done` after the 4th accept.
- `seed`=32'hFFFF_FFFE, `len`=3 → beats FFFF_FFFE, FFFF_FFFF, 0000_0000. `start` during SEND and `start` with `len`=0 are both ignored: `frame_count` advances by exactly 1.
- `len`=1, `seed`=32'h0024 → a single beat with `tvalid`=`tlast`=1. Back-to-back `start`s → second frame begins 2 cycles after the first accept.
- Reset asserted after the 2nd of 5 beats → `tvalid` drops in the same cycle, no `done`, `frame_count`=0. A new frame after release transmits correctly from its `seed`.
